// File: rtl/yonga_can_receiver.sv
// CAN receive controller: bus-idle integration, SOF detection, destuffing,
// standard/extended frame parsing, CRC-15 check, ACK drive and status report.
module yonga_can_receiver (
  input  logic        i_receiver_clk,
  input  logic        i_receiver_rst_n,
  input  logic        i_rx_enable,
  input  logic        i_sample_pulse,
  input  logic        i_drive_pulse,
  input  logic        i_message_bit,
  input  logic        i_tx_active,
  output logic        o_ack_bit,
  output logic [28:0] o_rx_id,
  output logic        o_rx_ide,
  output logic        o_rx_rtr,
  output logic [3:0]  o_rx_dlc,
  output logic [63:0] o_rx_data,
  output logic        o_rx_valid,
  output logic        o_rx_error,
  output logic [2:0]  o_sts_code,
  output logic        o_rx_busy
);

  typedef enum logic [3:0] {
    RX_BUS_IDLE, RX_WAIT_SOF, RX_FRAME, RX_CRC_DELIM, RX_ACK,
    RX_ACK_DELIM, RX_EOF, RX_INTERMISSION, RX_ERROR
  } rx_state_t;

  localparam logic [2:0] STS_OK    = 3'd1;
  localparam logic [2:0] STS_STUFF = 3'd2;
  localparam logic [2:0] STS_CRC   = 3'd3;
  localparam logic [2:0] STS_FORM  = 3'd4;

  rx_state_t   r_state, w_state_nxt;
  logic [3:0]  r_idle_cnt;
  logic [2:0]  r_run_cnt;
  logic        r_last_bit;
  logic [6:0]  r_idx;
  logic [2:0]  r_eof_cnt;
  logic        r_crc_ok;
  logic        r_ack_done;

  // Frame field registers; cleared at every SOF, so they carry no reset.
  logic [10:0] r_id_base;
  logic [17:0] r_id_ext;
  logic        r_srr_rtr;
  logic        r_ide;
  logic        r_rtr_ext;
  logic [3:0]  r_dlc;
  logic [63:0] r_data;
  logic [14:0] r_crc_calc;
  logic [14:0] r_crc_rx;

  logic        w_rtr;
  logic [6:0]  w_data_start;
  logic [6:0]  w_data_len;
  logic [6:0]  w_crc_start;
  logic [6:0]  w_crc_last;
  logic [5:0]  w_data_sel;
  logic        w_stuff_slot;
  logic        w_err;
  logic [2:0]  w_err_code;
  logic        w_crc_ok_nxt;

  // One CRC-15 (poly 0x4599) shift step for a single destuffed bit.
  function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[14];
    crc15_step = {crc[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
  endfunction

  assign w_rtr        = r_ide ? r_rtr_ext : r_srr_rtr;
  assign w_data_start = r_ide ? 7'd39 : 7'd19;
  assign w_data_len   = w_rtr ? 7'd0 : (r_dlc[3] ? 7'd64 : {1'b0, r_dlc[2:0], 3'b000});
  assign w_crc_start  = w_data_start + w_data_len;
  assign w_crc_last   = w_crc_start + 7'd14;
  assign w_data_sel   = 6'(7'd63 - (r_idx - w_data_start));
  assign w_stuff_slot = (r_run_cnt == 3'd5);

  // Next-state decode and error classification for the current sample.
  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_err_code  = 3'd0;
    if (!i_rx_enable) begin
      w_state_nxt = RX_BUS_IDLE;
    end else if (i_sample_pulse) begin
      case (r_state)
        RX_BUS_IDLE, RX_ERROR: begin
          if (i_message_bit && r_idle_cnt == 4'd10) w_state_nxt = RX_WAIT_SOF;
        end
        RX_WAIT_SOF: begin
          if (!i_message_bit) w_state_nxt = RX_FRAME;
        end
        RX_FRAME: begin
          if (w_stuff_slot) begin
            if (i_message_bit == r_last_bit) begin
              w_err      = 1'b1;
              w_err_code = STS_STUFF;
            end
          end else if (r_idx == w_crc_last) begin
            w_state_nxt = RX_CRC_DELIM;
          end
        end
        RX_CRC_DELIM: begin
          if (!i_message_bit) begin
            w_err      = 1'b1;
            w_err_code = STS_FORM;
          end else begin
            w_state_nxt = RX_ACK;
          end
        end
        RX_ACK: w_state_nxt = RX_ACK_DELIM;
        RX_ACK_DELIM: begin
          if (!i_message_bit) begin
            w_err      = 1'b1;
            w_err_code = STS_FORM;
          end else begin
            w_state_nxt = RX_EOF;
          end
        end
        RX_EOF: begin
          if (!i_message_bit) begin
            w_err      = 1'b1;
            w_err_code = STS_FORM;
          end else if (r_eof_cnt == 3'd6) begin
            w_state_nxt = RX_INTERMISSION;
          end
        end
        RX_INTERMISSION: begin
          if (!i_message_bit) begin
            w_err      = 1'b1;
            w_err_code = STS_FORM;
          end else if (r_eof_cnt == 3'd2) begin
            w_state_nxt = RX_WAIT_SOF;
          end
        end
        default: w_state_nxt = RX_BUS_IDLE;
      endcase
      if (w_err) w_state_nxt = RX_ERROR;
    end
  end

  assign w_crc_ok_nxt = (i_rx_enable && i_sample_pulse && r_state == RX_CRC_DELIM && i_message_bit)
                        ? (r_crc_calc == r_crc_rx) : r_crc_ok;

  // State register.
  always_ff @(posedge i_receiver_clk or negedge i_receiver_rst_n) begin
    if (!i_receiver_rst_n) r_state <= RX_BUS_IDLE;
    else                   r_state <= w_state_nxt;
  end

  // Counters, status, strobes, ACK drive and the frame output registers.
  always_ff @(posedge i_receiver_clk or negedge i_receiver_rst_n) begin
    if (!i_receiver_rst_n) begin
      r_idle_cnt <= 4'd0;
      r_run_cnt  <= 3'd0;
      r_last_bit <= 1'b0;
      r_idx      <= 7'd0;
      r_eof_cnt  <= 3'd0;
      r_crc_ok   <= 1'b0;
      r_ack_done <= 1'b0;
      o_ack_bit  <= 1'b1;
      o_rx_id    <= 29'd0;
      o_rx_ide   <= 1'b0;
      o_rx_rtr   <= 1'b0;
      o_rx_dlc   <= 4'd0;
      o_rx_data  <= 64'd0;
      o_rx_valid <= 1'b0;
      o_rx_error <= 1'b0;
      o_sts_code <= 3'd0;
      o_rx_busy  <= 1'b0;
    end else begin
      o_rx_valid <= 1'b0;
      o_rx_error <= 1'b0;
      if (!i_rx_enable) begin
        r_idle_cnt <= 4'd0;
        r_run_cnt  <= 3'd0;
        r_idx      <= 7'd0;
        r_eof_cnt  <= 3'd0;
        r_crc_ok   <= 1'b0;
        r_ack_done <= 1'b0;
        o_ack_bit  <= 1'b1;
        o_rx_busy  <= 1'b0;
      end else begin
        r_crc_ok <= w_crc_ok_nxt;
        if (i_sample_pulse) begin
          case (r_state)
            RX_BUS_IDLE, RX_ERROR: begin
              if (!i_message_bit || r_idle_cnt == 4'd10) r_idle_cnt <= 4'd0;
              else                                       r_idle_cnt <= r_idle_cnt + 4'd1;
            end
            RX_WAIT_SOF: begin
              if (!i_message_bit) begin
                o_rx_busy  <= 1'b1;
                o_sts_code <= 3'd0;
                r_run_cnt  <= 3'd1;
                r_last_bit <= 1'b0;
                r_idx      <= 7'd1;
                r_crc_ok   <= 1'b0;
                r_ack_done <= 1'b0;
              end
            end
            RX_FRAME: begin
              if (w_stuff_slot) begin
                r_run_cnt  <= 3'd1;
                r_last_bit <= i_message_bit;
              end else begin
                r_run_cnt  <= (i_message_bit == r_last_bit) ? r_run_cnt + 3'd1 : 3'd1;
                r_last_bit <= i_message_bit;
                r_idx      <= r_idx + 7'd1;
              end
            end
            RX_ACK_DELIM: r_eof_cnt <= 3'd0;
            RX_EOF: begin
              if (i_message_bit) begin
                if (r_eof_cnt == 3'd6) begin
                  r_eof_cnt <= 3'd0;
                  o_rx_busy <= 1'b0;
                  if (r_crc_ok) begin
                    o_rx_valid <= 1'b1;
                    o_sts_code <= STS_OK;
                    o_rx_id    <= r_ide ? {r_id_base, r_id_ext} : {18'd0, r_id_base};
                    o_rx_ide   <= r_ide;
                    o_rx_rtr   <= w_rtr;
                    o_rx_dlc   <= r_dlc;
                    o_rx_data  <= r_data;
                  end else begin
                    o_rx_error <= 1'b1;
                    o_sts_code <= STS_CRC;
                  end
                end else begin
                  r_eof_cnt <= r_eof_cnt + 3'd1;
                end
              end
            end
            RX_INTERMISSION: begin
              r_eof_cnt <= (r_eof_cnt == 3'd2) ? 3'd0 : r_eof_cnt + 3'd1;
            end
            default: ;
          endcase
        end
        if (w_err) begin
          o_sts_code <= w_err_code;
          o_rx_error <= 1'b1;
          o_rx_busy  <= 1'b0;
          o_ack_bit  <= 1'b1;
          r_idle_cnt <= 4'd0;
        end else if (i_drive_pulse) begin
          if (!o_ack_bit) begin
            o_ack_bit <= 1'b1;
          end else if (w_state_nxt == RX_ACK && w_crc_ok_nxt && !i_tx_active && !r_ack_done) begin
            o_ack_bit  <= 1'b0;
            r_ack_done <= 1'b1;
          end
        end
      end
    end
  end

  // Field capture from destuffed bits, data placement and running CRC.
  always_ff @(posedge i_receiver_clk) begin
    if (i_rx_enable && i_sample_pulse) begin
      if (r_state == RX_WAIT_SOF && !i_message_bit) begin
        r_id_base  <= 11'd0;
        r_id_ext   <= 18'd0;
        r_srr_rtr  <= 1'b0;
        r_ide      <= 1'b0;
        r_rtr_ext  <= 1'b0;
        r_dlc      <= 4'd0;
        r_data     <= 64'd0;
        r_crc_calc <= 15'd0;
        r_crc_rx   <= 15'd0;
      end else if (r_state == RX_FRAME && !w_stuff_slot) begin
        if (r_idx <= 7'd11)      r_id_base <= {r_id_base[9:0], i_message_bit};
        else if (r_idx == 7'd12) r_srr_rtr <= i_message_bit;
        else if (r_idx == 7'd13) r_ide     <= i_message_bit;
        else if (!r_ide) begin
          if (r_idx >= 7'd15 && r_idx <= 7'd18) r_dlc <= {r_dlc[2:0], i_message_bit};
        end else begin
          if (r_idx <= 7'd31)                        r_id_ext  <= {r_id_ext[16:0], i_message_bit};
          else if (r_idx == 7'd32)                   r_rtr_ext <= i_message_bit;
          else if (r_idx >= 7'd35 && r_idx <= 7'd38) r_dlc     <= {r_dlc[2:0], i_message_bit};
        end
        if (r_idx >= w_data_start && r_idx < w_crc_start) r_data[w_data_sel] <= i_message_bit;
        if (r_idx < w_crc_start) r_crc_calc <= crc15_step(r_crc_calc, i_message_bit);
        else                     r_crc_rx   <= {r_crc_rx[13:0], i_message_bit};
      end
    end
  end

endmodule

// File: tb/tb_yonga_can_receiver.sv
// Testbench for yonga_can_receiver: builds CAN frames from field values,
// stuffs them onto a modelled bus and compares the receiver's report.
module tb_yonga_can_receiver;

  logic        clk = 1'b0;
  logic        rst_n, en, sp, dp, mb, tx;
  logic        o_ack_bit;
  logic [28:0] o_rx_id;
  logic        o_rx_ide, o_rx_rtr;
  logic [3:0]  o_rx_dlc;
  logic [63:0] o_rx_data;
  logic        o_rx_valid, o_rx_error;
  logic [2:0]  o_sts_code;
  logic        o_rx_busy;

  always #5 clk = ~clk;

  yonga_can_receiver dut (
    .i_receiver_clk  (clk),
    .i_receiver_rst_n(rst_n),
    .i_rx_enable     (en),
    .i_sample_pulse  (sp),
    .i_drive_pulse   (dp),
    .i_message_bit   (mb),
    .i_tx_active     (tx),
    .o_ack_bit       (o_ack_bit),
    .o_rx_id         (o_rx_id),
    .o_rx_ide        (o_rx_ide),
    .o_rx_rtr        (o_rx_rtr),
    .o_rx_dlc        (o_rx_dlc),
    .o_rx_data       (o_rx_data),
    .o_rx_valid      (o_rx_valid),
    .o_rx_error      (o_rx_error),
    .o_sts_code      (o_sts_code),
    .o_rx_busy       (o_rx_busy)
  );

  int n_chk = 0, n_fail = 0;
  int n_valid = 0, n_errp = 0, n_ack_low = 0, n_wide = 0;
  int v0, e0, a0;
  logic prev_v = 1'b0, prev_e = 1'b0;

  // last frame the receiver should be presenting
  logic [28:0] e_id   = '0;
  logic        e_ide  = 1'b0, e_rtr = 1'b0;
  logic [3:0]  e_dlc  = '0;
  logic [63:0] e_data = '0;

  bit dq[$];
  bit sq[$];
  int ackdelim_pos, eof_pos, first_stuff;

  // pulse/ACK observer on the falling edge
  always @(negedge clk) begin
    if (o_rx_valid) n_valid++;
    if (o_rx_error) n_errp++;
    if (!o_ack_bit) n_ack_low++;
    if ((o_rx_valid && prev_v) || (o_rx_error && prev_e)) n_wide++;
    prev_v = o_rx_valid;
    prev_e = o_rx_error;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick_set(input bit d, input bit s, input bit b);
    @(posedge clk);
    #1;
    dp = d;
    sp = s;
    mb = b;
  endtask

  // one bus bit: drive point, then sample point two clocks later
  task automatic send_bit(input bit b);
    tick_set(1'b1, 1'b0, b);
    tick_set(1'b0, 1'b0, b);
    tick_set(1'b0, 1'b1, b);
    tick_set(1'b0, 1'b0, b);
  endtask

  task automatic idle(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  task automatic send_range(input int from, input int to);
    for (int i = from; i < to; i++) send_bit(sq[i]);
  endtask

  task automatic snap();
    v0 = n_valid;
    e0 = n_errp;
    a0 = n_ack_low;
  endtask

  task automatic check_deltas(input string tag, input int dv, input int de, input int da);
    check_val({tag, "_valid"}, 64'(n_valid - v0), 64'(dv));
    check_val({tag, "_error"}, 64'(n_errp - e0), 64'(de));
    check_val({tag, "_acklow"}, 64'(n_ack_low - a0), 64'(da));
  endtask

  task automatic check_frame_regs(input string tag);
    check_val({tag, "_id"}, 64'(o_rx_id), 64'(e_id));
    check_val({tag, "_ide"}, 64'(o_rx_ide), 64'(e_ide));
    check_val({tag, "_rtr"}, 64'(o_rx_rtr), 64'(e_rtr));
    check_val({tag, "_dlc"}, 64'(o_rx_dlc), 64'(e_dlc));
    check_val({tag, "_data"}, o_rx_data, e_data);
  endtask

  // Serialise a frame: destuffed field list, CRC by long division, then stuffing.
  task automatic build_frame(input logic [28:0] id, input bit ide, input bit rtr,
                             input logic [3:0] dlc, input logic [63:0] data, input int flip);
    bit m[$];
    logic [15:0] gen;
    int nb, n, run;
    bit last, b;
    gen = 16'hC599;
    dq.delete();
    dq.push_back(1'b0);
    if (!ide) begin
      for (int i = 10; i >= 0; i--) dq.push_back(id[i]);
      dq.push_back(rtr);
      dq.push_back(1'b0);
      dq.push_back(1'b0);
    end else begin
      for (int i = 28; i >= 18; i--) dq.push_back(id[i]);
      dq.push_back(1'b1);
      dq.push_back(1'b1);
      for (int i = 17; i >= 0; i--) dq.push_back(id[i]);
      dq.push_back(rtr);
      dq.push_back(1'b0);
      dq.push_back(1'b0);
    end
    for (int i = 3; i >= 0; i--) dq.push_back(dlc[i]);
    nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    for (int i = 0; i < nb * 8; i++) dq.push_back(data[63 - i]);
    n = dq.size();
    m = dq;
    for (int i = 0; i < 15; i++) m.push_back(1'b0);
    for (int i = 0; i < n; i++)
      if (m[i]) for (int j = 0; j < 16; j++) m[i + j] = m[i + j] ^ gen[15 - j];
    for (int i = 0; i < 15; i++) dq.push_back(m[n + i]);
    if (flip >= 0) dq[flip] = !dq[flip];
    sq.delete();
    first_stuff = -1;
    run = 0;
    last = 1'b0;
    for (int i = 0; i < dq.size(); i++) begin
      b = dq[i];
      if (i > 0 && run == 5) begin
        if (first_stuff < 0) first_stuff = sq.size();
        sq.push_back(!last);
        last = !last;
        run = 1;
      end
      sq.push_back(b);
      if (i > 0 && b == last) run++;
      else run = 1;
      last = b;
    end
    sq.push_back(1'b1);          // CRC delimiter
    sq.push_back(1'b1);          // ACK slot
    ackdelim_pos = sq.size();
    sq.push_back(1'b1);          // ACK delimiter
    eof_pos = sq.size();
    for (int i = 0; i < 10; i++) sq.push_back(1'b1);  // EOF + intermission
  endtask

  task automatic set_expect(input logic [28:0] id, input bit ide, input bit rtr,
                            input logic [3:0] dlc, input logic [63:0] data);
    int nb;
    e_id  = ide ? id : {18'd0, id[10:0]};
    e_ide = ide;
    e_rtr = rtr;
    e_dlc = dlc;
    nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    e_data = '0;
    for (int i = 0; i < nb * 8; i++) e_data[63 - i] = data[63 - i];
  endtask

  task automatic run_frame(input string tag, input logic [28:0] id, input bit ide, input bit rtr,
                           input logic [3:0] dlc, input logic [63:0] data, input bit txa, input int flip);
    build_frame(id, ide, rtr, dlc, data, flip);
    tx = txa;
    snap();
    idle(11);
    send_range(0, 10);
    check_val({tag, "_busy_mid"}, 64'(o_rx_busy), 64'd1);
    send_range(10, sq.size());
    if (flip < 0) begin
      set_expect(id, ide, rtr, dlc, data);
      check_deltas(tag, 1, 0, txa ? 0 : 4);
      check_val({tag, "_sts"}, 64'(o_sts_code), 64'd1);
    end else begin
      check_deltas(tag, 0, 1, 0);
      check_val({tag, "_sts"}, 64'(o_sts_code), 64'd3);
    end
    check_val({tag, "_busy_end"}, 64'(o_rx_busy), 64'd0);
    check_frame_regs(tag);
    tx = 1'b0;
  endtask

  task automatic form_test(input string tag, input int pos);
    build_frame(29'h155, 1'b0, 1'b0, 4'd1, 64'h3C00_0000_0000_0000, -1);
    sq[pos] = 1'b0;
    snap();
    idle(11);
    send_range(0, sq.size());
    check_deltas(tag, 0, 1, 4);
    check_val({tag, "_sts"}, 64'(o_sts_code), 64'd4);
    check_val({tag, "_busy"}, 64'(o_rx_busy), 64'd0);
    check_frame_regs(tag);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; sp = 1'b0; dp = 1'b0; mb = 1'b1; tx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_ack", 64'(o_ack_bit), 64'd1);
    check_val("rst_busy", 64'(o_rx_busy), 64'd0);
    check_val("rst_sts", 64'(o_sts_code), 64'd0);
    check_val("rst_valid", 64'(o_rx_valid), 64'd0);
    check_val("rst_error", 64'(o_rx_error), 64'd0);
    check_frame_regs("rst");

    run_frame("std123", 29'h123, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 1'b0, -1);
    run_frame("ext_rtr", 29'h1ABCDEF1, 1'b1, 1'b1, 4'd12, 64'h0123_4567_89AB_CDEF, 1'b0, -1);
    run_frame("ext_data", 29'h1ABCDEF1, 1'b1, 1'b0, 4'd12, 64'hFEDC_BA98_7654_3210, 1'b0, -1);
    run_frame("txact", 29'h07F, 1'b0, 1'b0, 4'd3, 64'h0000_0000_0000_0000, 1'b1, -1);

    // stuff error: six dominant bits inside the identifier
    build_frame(29'h400, 1'b0, 1'b0, 4'd0, 64'd0, -1);
    sq[first_stuff] = 1'b0;
    snap();
    idle(11);
    send_range(0, first_stuff + 1);
    send_bit(1'b1);
    check_deltas("stuff", 0, 1, 0);
    check_val("stuff_sts", 64'(o_sts_code), 64'd2);
    check_val("stuff_busy", 64'(o_rx_busy), 64'd0);
    check_frame_regs("stuff");
    // only 10 recessive bits after the error: the following frame is ignored
    build_frame(29'h0AA, 1'b0, 1'b0, 4'd1, 64'h9900_0000_0000_0000, -1);
    snap();
    idle(9);
    send_range(0, sq.size());
    check_deltas("stuff_skip", 0, 0, 0);
    check_val("stuff_skip_sts", 64'(o_sts_code), 64'd2);
    check_frame_regs("stuff_skip");
    run_frame("after_stuff", 29'h0AA, 1'b0, 1'b0, 4'd1, 64'h9900_0000_0000_0000, 1'b0, -1);

    run_frame("crcerr", 29'h2A5, 1'b0, 1'b0, 4'd4, 64'h1122_3344_0000_0000, 1'b0, 24);

    build_frame(29'h155, 1'b0, 1'b0, 4'd1, 64'h3C00_0000_0000_0000, -1);
    form_test("ackdelim", ackdelim_pos);
    form_test("eof4", eof_pos + 3);

    // reset mid-data
    build_frame(29'h321, 1'b0, 1'b0, 4'd8, 64'hDEAD_BEEF_CAFE_F00D, -1);
    snap();
    idle(11);
    send_range(0, 30);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    e_id = '0; e_ide = 1'b0; e_rtr = 1'b0; e_dlc = '0; e_data = '0;
    check_deltas("rstmid", 0, 0, 0);
    check_val("rstmid_busy", 64'(o_rx_busy), 64'd0);
    check_val("rstmid_ack", 64'(o_ack_bit), 64'd1);
    check_val("rstmid_sts", 64'(o_sts_code), 64'd0);
    check_frame_regs("rstmid");
    rst_n = 1'b1;
    run_frame("after_rst", 29'h321, 1'b0, 1'b0, 4'd8, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, -1);

    // enable dropped mid-data
    build_frame(29'h0C0FFEE, 1'b1, 1'b0, 4'd5, 64'h0102_0304_0500_0000, -1);
    snap();
    idle(11);
    send_range(0, 50);
    en = 1'b0;
    idle(3);
    check_deltas("endrop", 0, 0, 0);
    check_val("endrop_busy", 64'(o_rx_busy), 64'd0);
    check_val("endrop_ack", 64'(o_ack_bit), 64'd1);
    check_val("endrop_sts", 64'(o_sts_code), 64'd0);
    check_frame_regs("endrop");
    en = 1'b1;
    run_frame("after_en", 29'h0C0FFEE, 1'b1, 1'b0, 4'd5, 64'h0102_0304_0500_0000, 1'b0, -1);

    for (int k = 0; k < 14; k++) begin
      logic [28:0] rid;
      logic [3:0]  rdlc;
      logic [63:0] rdata;
      bit          ride, rrtr, rtx;
      rid   = 29'($urandom);
      ride  = 1'($urandom % 2);
      rrtr  = ($urandom % 4) == 0;
      rdlc  = 4'($urandom % 16);
      rdata = {$urandom, $urandom};
      rtx   = ($urandom % 4) == 0;
      run_frame($sformatf("rnd%0d", k), rid, ride, rrtr, rdlc, rdata, rtx, -1);
    end

    check_val("pulse_width", 64'(n_wide), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
    $finish;
  end

endmodule
